// File: rtl/laser_host_if.sv
// Host <-> controller/solver signal bundle for laser_host.
// master: the host block itself; slave: the controller/solver side.
interface laser_host_if;
    logic       load_en;
    logic [5:0] load_addr;
    logic [3:0] load_x;
    logic [3:0] load_y;
    logic       start;
    logic       busy;
    logic       laser_rst;
    logic [3:0] X;
    logic [3:0] Y;
    logic       DONE;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic       res_valid;
    logic [5:0] res_cnt;
    logic [3:0] res_c1x;
    logic [3:0] res_c1y;
    logic [3:0] res_c2x;
    logic [3:0] res_c2y;
    logic       res_timeout;

    modport master (
        input  load_en, load_addr, load_x, load_y, start, DONE, C1X, C1Y, C2X, C2Y,
        output busy, laser_rst, X, Y, res_valid, res_cnt,
               res_c1x, res_c1y, res_c2x, res_c2y, res_timeout
    );
    modport slave (
        output load_en, load_addr, load_x, load_y, start, DONE, C1X, C1Y, C2X, C2Y,
        input  busy, laser_rst, X, Y, res_valid, res_cnt,
               res_c1x, res_c1y, res_c2x, res_c2y, res_timeout
    );
endinterface

// File: rtl/laser_host.sv
// Host for the LASER solver: buffers one point image, streams it to the solver,
// captures the two centres and scores how many buffered points they cover.
module laser_host #(
    parameter int NPTS      = 40,
    parameter int RADIUS_SQ = 16,
    parameter int TO_W      = 12
) (
    input logic          CLK,
    input logic          RST,
    laser_host_if.master bus
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT, SCORE, REPORT} state_e;

    state_e          state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            laser_rst_q, laser_rst_d;
    logic            busy_q, busy_d;
    logic [3:0]      x_q, x_d, y_q, y_d;
    logic            res_valid_q, res_valid_d;
    logic [5:0]      res_cnt_q, res_cnt_d;
    logic [3:0]      c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
    logic            res_timeout_q, res_timeout_d;

    logic [3:0] mem_x [NPTS];
    logic [3:0] mem_y [NPTS];
    logic       we;
    logic [3:0] pt_x, pt_y;
    logic       hit;

    function automatic logic in_circle(input logic [3:0] px, py, cx, cy);
        logic [3:0] dx, dy;
        logic [7:0] dx2, dy2;
        logic [8:0] d2;
        dx  = (px > cx) ? px - cx : cx - px;
        dy  = (py > cy) ? py - cy : cy - py;
        dx2 = 8'(dx) * 8'(dx);
        dy2 = 8'(dy) * 8'(dy);
        d2  = 9'(dx2) + 9'(dy2);
        return d2 <= 9'(RADIUS_SQ);
    endfunction

    // Buffer is frozen while a run is in flight.
    assign we   = (state_q == IDLE) && bus.load_en && (bus.load_addr < 6'(NPTS));
    assign pt_x = mem_x[idx_q];
    assign pt_y = mem_y[idx_q];
    assign hit  = in_circle(pt_x, pt_y, c1x_q, c1y_q) || in_circle(pt_x, pt_y, c2x_q, c2y_q);

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_x[bus.load_addr] <= bus.load_x;
            mem_y[bus.load_addr] <= bus.load_y;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        to_cnt_d      = to_cnt_q;
        laser_rst_d   = laser_rst_q;
        x_d           = x_q;
        y_d           = y_q;
        res_valid_d   = 1'b0;
        res_cnt_d     = res_cnt_q;
        c1x_d         = c1x_q;
        c1y_d         = c1y_q;
        c2x_d         = c2x_q;
        c2y_d         = c2y_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            IDLE: begin
                laser_rst_d = 1'b1;
                x_d         = 4'd0;
                y_d         = 4'd0;
                if (bus.start) begin
                    laser_rst_d = 1'b0;
                    // A same-cycle write to point 0 must reach the stream.
                    if (we && bus.load_addr == 6'd0) begin
                        x_d = bus.load_x;
                        y_d = bus.load_y;
                    end else begin
                        x_d = mem_x[0];
                        y_d = mem_y[0];
                    end
                    idx_d   = 6'd1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (idx_q == 6'(NPTS)) begin
                    x_d      = 4'd0;
                    y_d      = 4'd0;
                    to_cnt_d = '0;
                    state_d  = WAIT;
                end else begin
                    x_d   = pt_x;
                    y_d   = pt_y;
                    idx_d = idx_q + 6'd1;
                end
            end
            WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (bus.DONE) begin
                    c1x_d         = bus.C1X;
                    c1y_d         = bus.C1Y;
                    c2x_d         = bus.C2X;
                    c2y_d         = bus.C2Y;
                    res_cnt_d     = 6'd0;
                    res_timeout_d = 1'b0;
                    idx_d         = 6'd0;
                    state_d       = SCORE;
                end else if (to_cnt_d == '1) begin
                    c1x_d         = 4'd0;
                    c1y_d         = 4'd0;
                    c2x_d         = 4'd0;
                    c2y_d         = 4'd0;
                    res_cnt_d     = 6'd0;
                    res_timeout_d = 1'b1;
                    state_d       = REPORT;
                end
            end
            SCORE: begin
                if (hit && res_cnt_q < 6'(NPTS)) res_cnt_d = res_cnt_q + 6'd1;
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'(NPTS - 1)) state_d = REPORT;
            end
            REPORT: begin
                res_valid_d = 1'b1;
                laser_rst_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            idx_q         <= 6'd0;
            to_cnt_q      <= '0;
            laser_rst_q   <= 1'b1;
            busy_q        <= 1'b0;
            x_q           <= 4'd0;
            y_q           <= 4'd0;
            res_valid_q   <= 1'b0;
            res_cnt_q     <= 6'd0;
            c1x_q         <= 4'd0;
            c1y_q         <= 4'd0;
            c2x_q         <= 4'd0;
            c2y_q         <= 4'd0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            to_cnt_q      <= to_cnt_d;
            laser_rst_q   <= laser_rst_d;
            busy_q        <= busy_d;
            x_q           <= x_d;
            y_q           <= y_d;
            res_valid_q   <= res_valid_d;
            res_cnt_q     <= res_cnt_d;
            c1x_q         <= c1x_d;
            c1y_q         <= c1y_d;
            c2x_q         <= c2x_d;
            c2y_q         <= c2y_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.laser_rst   = laser_rst_q;
    assign bus.X           = x_q;
    assign bus.Y           = y_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_cnt     = res_cnt_q;
    assign bus.res_c1x     = c1x_q;
    assign bus.res_c1y     = c1y_q;
    assign bus.res_c2x     = c2x_q;
    assign bus.res_c2y     = c2y_q;
    assign bus.res_timeout = res_timeout_q;
endmodule

// File: tb/tb_laser_host.sv
// Directed bench for laser_host: the bench plays both controller and solver.
module tb_laser_host;
    localparam int NPTS = 40;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [3:0] cap_x [NPTS+1];
    logic [3:0] cap_y [NPTS+1];
    logic       cap_r [NPTS+1];
    logic [3:0] exp_x [NPTS];
    logic [3:0] exp_y [NPTS];

    laser_host_if bus ();
    laser_host #(.NPTS(NPTS), .RADIUS_SQ(16), .TO_W(12)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mode 0: all (5,5); 1: (k%16,k/16); 2: boundary set; 3: all (7,8)
    task automatic load_pattern(input int mode);
        for (int k = 0; k < NPTS; k++) begin
            case (mode)
                0: begin exp_x[k] = 4'd5; exp_y[k] = 4'd5; end
                1: begin exp_x[k] = 4'(k % 16); exp_y[k] = 4'(k / 16); end
                2: begin
                    exp_x[k] = (k == 0) ? 4'd9 : (k == 1) ? 4'd8 : 4'd15;
                    exp_y[k] = (k == 0) ? 4'd5 : (k == 1) ? 4'd8 : 4'd0;
                end
                default: begin exp_x[k] = 4'd7; exp_y[k] = 4'd8; end
            endcase
            bus.load_en   = 1'b1;
            bus.load_addr = 6'(k);
            bus.load_x    = exp_x[k];
            bus.load_y    = exp_y[k];
            tick();
        end
        bus.load_en = 1'b0;
    endtask

    // Pulse start and record X/Y/laser_rst for the NPTS+1 cycles that follow.
    // At cycle inj, start/load_en/DONE are poked to check they are ignored.
    task automatic run_stream(input int inj);
        bus.start = 1'b1;
        for (int c = 0; c <= NPTS; c++) begin
            tick();
            bus.start   = 1'b0;
            bus.load_en = 1'b0;
            bus.DONE    = 1'b0;
            if (c == inj) begin
                bus.start     = 1'b1;
                bus.load_en   = 1'b1;
                bus.load_addr = 6'd30;
                bus.load_x    = 4'd15;
                bus.load_y    = 4'd15;
                bus.DONE      = 1'b1;
            end
            cap_x[c] = bus.X;
            cap_y[c] = bus.Y;
            cap_r[c] = bus.laser_rst;
        end
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        bus.DONE    = 1'b0;
    endtask

    // Solver answers after dly WAIT cycles; n = cycles from DONE edge to res_valid.
    task automatic finish_run(input int dly, input logic [3:0] c1x, c1y, c2x, c2y, output int n);
        repeat (dly) tick();
        bus.C1X = c1x; bus.C1Y = c1y; bus.C2X = c2x; bus.C2Y = c2y;
        bus.DONE = 1'b1;
        tick();
        bus.DONE = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        n_checks++;
        if ({bus.laser_rst, bus.busy, bus.res_valid, bus.res_timeout} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 1000",
                     {bus.laser_rst, bus.busy, bus.res_valid, bus.res_timeout});
        end
        n_checks++;
        if ({bus.X, bus.Y, bus.res_cnt} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_data: X=%0d Y=%0d cnt=%0d expected all 0", bus.X, bus.Y, bus.res_cnt);
        end
        n_checks++;
        if ({bus.res_c1x, bus.res_c1y, bus.res_c2x, bus.res_c2y} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_centres: got %h expected 0000",
                     {bus.res_c1x, bus.res_c1y, bus.res_c2x, bus.res_c2y});
        end
    endtask

    task automatic test_uniform();
        int n;
        load_pattern(0);
        run_stream(-1);
        for (int k = 0; k < NPTS; k++) begin
            n_checks++;
            if ({cap_x[k], cap_y[k], cap_r[k]} !== {4'd5, 4'd5, 1'b0}) begin
                n_fail++;
                $display("FAIL uniform_stream[%0d]: got (%0d,%0d,rst=%b) expected (5,5,rst=0)",
                         k, cap_x[k], cap_y[k], cap_r[k]);
            end
        end
        n_checks++;
        if ({cap_x[NPTS], cap_y[NPTS]} !== 8'h00) begin
            n_fail++;
            $display("FAIL uniform_tail: got (%0d,%0d) expected (0,0)", cap_x[NPTS], cap_y[NPTS]);
        end
        finish_run(3, 4'd5, 4'd5, 4'd10, 4'd10, n);
        n_checks++;
        if (n !== 41) begin
            n_fail++;
            $display("FAIL uniform_latency: got %0d expected 41", n);
        end
        n_checks++;
        if ({bus.res_cnt, bus.res_c1x, bus.res_c2y, bus.res_timeout} !== {6'd40, 4'd5, 4'd10, 1'b0}) begin
            n_fail++;
            $display("FAIL uniform_result: cnt=%0d c1x=%0d c2y=%0d to=%b expected 40 5 10 0",
                     bus.res_cnt, bus.res_c1x, bus.res_c2y, bus.res_timeout);
        end
        tick();
        n_checks++;
        if ({bus.res_valid, bus.busy, bus.laser_rst, bus.res_cnt} !== {3'b001, 6'd40}) begin
            n_fail++;
            $display("FAIL uniform_after: valid=%b busy=%b rst=%b cnt=%0d expected 0 0 1 40",
                     bus.res_valid, bus.busy, bus.laser_rst, bus.res_cnt);
        end
    endtask

    // Shared stream comparison against exp_x/exp_y for the indexed pattern runs.
    task automatic test_index_stream(input string tag, input int inj, input int exp_cnt);
        int n;
        run_stream(inj);
        for (int k = 0; k <= NPTS; k++) begin
            n_checks++;
            if ({cap_x[k], cap_y[k], cap_r[k]} !==
                {(k < NPTS) ? exp_x[k] : 4'd0, (k < NPTS) ? exp_y[k] : 4'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL %s_stream[%0d]: got (%0d,%0d,rst=%b) expected (%0d,%0d,rst=0)", tag, k,
                         cap_x[k], cap_y[k], cap_r[k],
                         (k < NPTS) ? exp_x[k] : 4'd0, (k < NPTS) ? exp_y[k] : 4'd0);
            end
        end
        finish_run(0, 4'd0, 4'd0, 4'd15, 4'd0, n);
        n_checks++;
        if ({n[7:0], bus.res_cnt} !== {8'd41, 6'(exp_cnt)}) begin
            n_fail++;
            $display("FAIL %s_result: latency=%0d cnt=%0d expected 41 %0d", tag, n, bus.res_cnt, exp_cnt);
        end
        tick();
    endtask

    task automatic test_boundary();
        int n;
        load_pattern(2);
        run_stream(-1);
        finish_run(1, 4'd5, 4'd5, 4'd0, 4'd15, n);
        n_checks++;
        if ({bus.res_cnt, bus.res_c2x, bus.res_c2y} !== {6'd1, 4'd0, 4'd15}) begin
            n_fail++;
            $display("FAIL boundary_cnt: cnt=%0d c2=(%0d,%0d) expected 1 (0,15)",
                     bus.res_cnt, bus.res_c2x, bus.res_c2y);
        end
        tick();
    endtask

    task automatic test_overlap();
        int n;
        load_pattern(3);
        run_stream(-1);
        finish_run(2, 4'd7, 4'd7, 4'd7, 4'd7, n);
        n_checks++;
        if (bus.res_cnt !== 6'd40) begin
            n_fail++;
            $display("FAIL overlap_cnt: got %0d expected 40", bus.res_cnt);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        run_stream(-1);
        n = 0;
        while (!bus.res_valid && n < 5000) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 4096) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d expected 4096", n);
        end
        n_checks++;
        if ({bus.res_valid, bus.res_timeout, bus.busy, bus.laser_rst, bus.res_cnt, bus.res_c1x, bus.res_c1y}
            !== {4'b1101, 6'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL timeout_result: valid=%b to=%b busy=%b rst=%b cnt=%0d c1=(%0d,%0d) expected 1 1 0 1 0 (0,0)",
                     bus.res_valid, bus.res_timeout, bus.busy, bus.laser_rst, bus.res_cnt,
                     bus.res_c1x, bus.res_c1y);
        end
        tick();
        n_checks++;
        if ({bus.res_valid, bus.res_timeout} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_hold: valid=%b to=%b expected 0 1", bus.res_valid, bus.res_timeout);
        end
    endtask

    task automatic test_rst_mid_send();
        int seen = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if ({bus.laser_rst, bus.busy, bus.res_valid, bus.X, bus.Y} !== {3'b100, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_send: rst=%b busy=%b valid=%b X=%0d Y=%0d expected 1 0 0 0 0",
                     bus.laser_rst, bus.busy, bus.res_valid, bus.X, bus.Y);
        end
        bus.DONE = 1'b1;
        repeat (60) begin
            tick();
            if (bus.res_valid || bus.busy) seen++;
        end
        bus.DONE = 1'b0;
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_no_result: got %0d active cycles expected 0", seen);
        end
    endtask

    initial begin
        bus.load_en = 1'b0; bus.load_addr = 6'd0; bus.load_x = 4'd0; bus.load_y = 4'd0;
        bus.start = 1'b0; bus.DONE = 1'b0;
        bus.C1X = 4'd0; bus.C1Y = 4'd0; bus.C2X = 4'd0; bus.C2Y = 4'd0;
        test_reset();
        test_uniform();
        load_pattern(1);
        test_index_stream("index", -1, 22);
        test_boundary();
        test_overlap();
        test_timeout();
        load_pattern(1);
        // start, load_en and DONE poked mid-SEND must not disturb anything
        test_index_stream("abuse", 10, 22);
        test_rst_mid_send();
        // write-first with start: point 0 replaced by (9,9), which no centre covers
        bus.load_en = 1'b1; bus.load_addr = 6'd0; bus.load_x = 4'd9; bus.load_y = 4'd9;
        exp_x[0] = 4'd9; exp_y[0] = 4'd9;
        test_index_stream("restart", -1, 21);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
